// File: rtl/uc_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier control unit:
// state encodings, default widths and the Moore output decode.
package uc_shift_add_pkg;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic clr_p;
    logic add_en;
    logic sh;
    logic busy;
    logic fin;
  } ctl_t;

  // One strobe group per state; unused encodings decode to all-zero.
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_LOAD:  begin c.ld_a = 1'b1; c.ld_b = 1'b1; c.clr_p = 1'b1; c.busy = 1'b1; end
      S_TEST:  c.busy = 1'b1;
      S_ADD:   begin c.add_en = 1'b1; c.busy = 1'b1; end
      S_SHIFT: begin c.sh = 1'b1; c.busy = 1'b1; end
      S_DONE:  c.fin = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uc_shift_add_if.sv
// Control/status bundle between the control unit and the multiplier datapath.
interface uc_shift_add_if;
  logic xs;
  logic z;
  logic ld_a;
  logic ld_b;
  logic clr_p;
  logic add_en;
  logic sh;
  logic busy;
  logic fin;

  modport master (
    input  xs, z,
    output ld_a, ld_b, clr_p, add_en, sh, busy, fin
  );

  modport slave (
    output xs, z,
    input  ld_a, ld_b, clr_p, add_en, sh, busy, fin
  );
endinterface

// File: rtl/uc_shift_add_cnt_down.sv
// CW-bit down-counter with synchronous load, saturating decrement and zero flag.
module cnt_down #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  assign zero = (cnt == '0);

  // Decrement is gated by !zero so the count can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (load)         cnt <= din;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/uc_shift_add.sv
// Moore control FSM for the shift-and-add multiplier: LOAD, then N passes of
// TEST/(ADD)/SHIFT, then DONE until xs returns to zero.
module uc_shift_add
  import uc_shift_add_pkg::*;
#(
  parameter int N  = N_DEF,  // 1..255
  parameter int CW = CW_DEF  // 2**CW >= N
) (
  input  logic           clk,
  input  logic           reset,
  uc_shift_add_if.master bus
);

  state_t        state, nxt;
  ctl_t          ctl;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  cnt_down #(.CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (state == S_LOAD),
    .dec   (state == S_SHIFT),
    .din   (CW'(N - 1)),
    .cnt   (cnt),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.xs) nxt = S_LOAD;
      S_LOAD:  nxt = S_TEST;
      S_TEST:  nxt = bus.z ? S_ADD : S_SHIFT;
      S_ADD:   nxt = S_SHIFT;
      S_SHIFT: nxt = cnt_zero ? S_DONE : S_TEST;
      S_DONE:  if (!bus.xs) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign ctl        = decode(state);
  assign bus.ld_a   = ctl.ld_a;
  assign bus.ld_b   = ctl.ld_b;
  assign bus.clr_p  = ctl.clr_p;
  assign bus.add_en = ctl.add_en;
  assign bus.sh     = ctl.sh;
  assign bus.busy   = ctl.busy;
  assign bus.fin    = ctl.fin;

endmodule

// File: tb/tb_uc_shift_add.sv
// Bench for uc_shift_add: three instances (N=4, 8, 1) against a trace-based
// model that predicts each operation's output sequence from the operand bits.
module tb_uc_shift_add;

  // {ld_a, ld_b, clr_p, add_en, sh, busy, fin}
  localparam logic [6:0] V_IDLE = 7'b0000000;
  localparam logic [6:0] V_LOAD = 7'b1110010;
  localparam logic [6:0] V_TEST = 7'b0000010;
  localparam logic [6:0] V_ADD  = 7'b0001010;
  localparam logic [6:0] V_SH   = 7'b0000110;
  localparam logic [6:0] V_DONE = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] xs = 3'b000;
  logic [2:0] z;
  logic [7:0] op   [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] mreg [3] = '{8'hFF, 8'hFF, 8'hFF};
  logic [6:0] got  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uc_shift_add_if b0 ();
  uc_shift_add_if b1 ();
  uc_shift_add_if b2 ();

  assign b0.xs = xs[0];
  assign b1.xs = xs[1];
  assign b2.xs = xs[2];
  assign z[0]  = mreg[0][0];
  assign z[1]  = mreg[1][0];
  assign z[2]  = mreg[2][0];
  assign b0.z  = z[0];
  assign b1.z  = z[1];
  assign b2.z  = z[2];
  assign got[0] = {b0.ld_a, b0.ld_b, b0.clr_p, b0.add_en, b0.sh, b0.busy, b0.fin};
  assign got[1] = {b1.ld_a, b1.ld_b, b1.clr_p, b1.add_en, b1.sh, b1.busy, b1.fin};
  assign got[2] = {b2.ld_a, b2.ld_b, b2.clr_p, b2.add_en, b2.sh, b2.busy, b2.fin};

  uc_shift_add #(.N(4), .CW(2)) u4 (.clk(clk), .reset(reset), .bus(b0));
  uc_shift_add #(.N(8), .CW(3)) u8 (.clk(clk), .reset(reset), .bus(b1));
  uc_shift_add #(.N(1), .CW(1)) u1 (.clk(clk), .reset(reset), .bus(b2));

  function automatic int nof(int c);
    return (c == 0) ? 4 : (c == 1) ? 8 : 1;
  endfunction

  // Datapath stand-in: multiplier register loaded on ld_b, shifted right on sh.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (got[c][5])      mreg[c] <= op[c];
      else if (got[c][2]) mreg[c] <= mreg[c] >> 1;
    end
  end

  // Model: on start, lay out the whole expected strobe trace for the operand.
  int         mode [3];
  int         tlen [3];
  int         tptr [3];
  logic [6:0] tr   [3][32];

  always @(posedge clk or negedge reset) begin
    for (int c = 0; c < 3; c++) begin
      if (!reset) mode[c] = 0;
      else begin
        case (mode[c])
          0: if (xs[c]) begin
            tlen[c] = 0;
            tr[c][tlen[c]] = V_LOAD; tlen[c]++;
            for (int i = 0; i < nof(c); i++) begin
              tr[c][tlen[c]] = V_TEST; tlen[c]++;
              if (op[c][i]) begin tr[c][tlen[c]] = V_ADD; tlen[c]++; end
              tr[c][tlen[c]] = V_SH; tlen[c]++;
            end
            tptr[c] = 0;
            mode[c] = 1;
          end
          1: begin
            tptr[c]++;
            if (tptr[c] == tlen[c]) mode[c] = 2;
          end
          default: if (!xs[c]) mode[c] = 0;
        endcase
      end
    end
  end

  function automatic logic [6:0] expv(int c);
    if (mode[c] == 0) return V_IDLE;
    if (mode[c] == 1) return tr[c][tptr[c]];
    return V_DONE;
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (got[c] !== expv(c)) begin
        errors++;
        $display("FAIL cycle_cmp ch%0d t=%0t got %b exp %b", c, $time, got[c], expv(c));
      end
    end
  end

  task automatic check(input string name, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, g, e);
    end
  endtask

  // Called #1 after a posedge with channel c idle; returns edges to DONE and pulse counts.
  task automatic run(input int c, input logic [7:0] o, input int drop,
                     output int k, output int adds, output int shs, output int lds);
    op[c] = o;
    xs[c] = 1'b1;
    @(posedge clk); #1;
    k = 0;
    adds = int'(got[c][3]); shs = int'(got[c][2]); lds = int'(got[c][6]);
    while (!got[c][0] && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k == drop) xs[c] = 1'b0;
      adds += int'(got[c][3]); shs += int'(got[c][2]); lds += int'(got[c][6]);
    end
    if (!got[c][0]) check("fin_timeout", 0, 1);
  endtask

  int k, adds, shs, lds, n, mask, c;
  logic [7:0] o;
  logic found;

  initial begin
    // Reset held with xs=1, z=1
    xs = 3'b111;
    op[1] = 8'($urandom);
    op[2] = 8'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("reset_outputs", int'(got[i]), 0);
    reset = 1'b1;

    // N=4, multiplier 1011, xs held
    run(0, 8'h0B, 0, k, adds, shs, lds);
    check("n4_1011_latency", k, 12);
    check("n4_1011_adds", adds, 3);
    check("n4_1011_shifts", shs, 4);
    check("n4_1011_loads", lds, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("done_hold", int'(got[0]), int'(V_DONE));
    end
    xs = 3'b000;
    @(posedge clk); #1;
    check("fin_fall", int'(got[0][0]), 0);
    repeat (30) @(posedge clk);
    #1;

    // N=4, all zeros then all ones (also a 1->0->1 retrigger)
    run(0, 8'h00, 0, k, adds, shs, lds);
    check("n4_zero_latency", k, 9);
    check("n4_zero_adds", adds, 0);
    check("n4_zero_shifts", shs, 4);
    xs[0] = 1'b0;
    @(posedge clk); #1;
    run(0, 8'h0F, 0, k, adds, shs, lds);
    check("n4_ones_latency", k, 13);
    check("n4_ones_adds", adds, 4);
    check("n4_ones_loads", lds, 1);
    xs[0] = 1'b0;
    @(posedge clk); #1;

    // N=8, xs dropped two cycles after start
    run(1, 8'h00, 2, k, adds, shs, lds);
    check("n8_drop_latency", k, 17);
    @(posedge clk); #1;
    check("n8_drop_fin_1cycle", int'(got[1]), 0);

    // Reset during the SHIFT of bit 2
    o = 8'($urandom);
    op[1] = o;
    xs[1] = 1'b1;
    n = 0; found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (got[1][2]) begin
        if (n == 2) found = 1'b1;
        else n++;
      end
    end
    check("reach_shift_bit2", int'(found), 1);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("async_drop", int'(got[i]), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run(1, o, 0, k, adds, shs, lds);
    check("post_reset_shifts", shs, 8);
    check("post_reset_loads", lds, 1);
    check("post_reset_latency", k, 17 + $countones(o));
    xs[1] = 1'b0;
    @(posedge clk); #1;

    // Randomized operations
    repeat (40) begin
      c = $urandom_range(0, 2);
      o = 8'($urandom);
      mask = (1 << nof(c)) - 1;
      run(c, o, $urandom_range(0, 30), k, adds, shs, lds);
      check("rand_latency", k, 1 + 2 * nof(c) + $countones(int'(o) & mask));
      check("rand_shifts", shs, nof(c));
      xs[c] = 1'b1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 xs[c] = 1'b0;
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
